// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: start-of-frame marker,
// parser error codes and the parser state encoding.
package uart_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  localparam logic [1:0] ERR_BAD_LEN = 2'd0;
  localparam logic [1:0] ERR_BAD_CHK = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;

  // Frame checksum accumulation: 8-bit wrapping sum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Packet payload store: DEPTH x 8 register array, one synchronous write
// port and one combinational read port.
module uart_pkt_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Frames SOF/LEN/PAYLOAD/CHK packets out of the received byte stream and
// replays only checksum-verified payloads on a valid/ready byte stream.
module uart_rx_pkt_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 208320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  // The counter value from which the next idle cycle would reach TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYCLES - 2);

  // Handshake: a byte moves when out_valid and out_ready are both high at a
  // rising edge; out_valid never drops and out_data never changes before that.
  logic [2:0]       state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;
  logic [7:0]       rd_idx_q, rd_idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             out_valid_q;
  logic             pkt_ok_q, pkt_ok_d;
  logic             pkt_err_q, pkt_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q;
  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             hs;
  logic             rd_last;
  logic             in_frame;

  assign hs       = out_valid_q && out_ready;
  assign rd_last  = (rd_idx_q == (len_q - 8'd1));
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_idx_d   = rd_idx_q;
    sum_d      = sum_q;
    tmo_d      = '0;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_data == SOF_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (in_valid) begin
          if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_BAD_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d    = in_data;
            wr_cnt_d = 8'd0;
            sum_d    = in_data;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          buf_we   = 1'b1;
          sum_d    = sum8(sum_q, in_data);
          wr_cnt_d = wr_cnt_q + 8'd1;
          if (wr_cnt_q == (len_q - 8'd1)) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (in_valid) begin
          if (in_data == sum_q) begin
            rd_idx_d = 8'd0;
            state_d  = ST_EMIT;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_BAD_CHK;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        // Input cannot be stalled, so anything arriving now is lost.
        if (in_valid) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (hs) begin
          if (rd_last) begin
            pkt_ok_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte in the expiry cycle takes precedence over the timeout.
    if (in_frame && !in_valid) begin
      if (tmo_q == TMO_FIRE) begin
        pkt_err_d  = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      wr_cnt_q    <= 8'd0;
      rd_idx_q    <= 8'd0;
      sum_q       <= 8'd0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_BAD_LEN;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      out_valid_q <= (state_d == ST_EMIT);
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_cnt_q[IDX_W-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_idx_q[IDX_W-1:0]),
    .rdata_o (buf_rdata)
  );

  // Gated so stale buffer contents never show outside EMIT or after reset.
  assign out_data  = out_valid_q ? buf_rdata : 8'h00;
  assign out_last  = out_valid_q && rd_last;
  assign out_valid = out_valid_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/uart_rx_pkt_parser.md
# uart_rx_pkt_parser

Downstream stage of the UART receiver. Consumes the received byte stream (byte + one-cycle done pulse) and extracts framed packets of the form SOF, LEN, PAYLOAD[LEN], CHK. Each packet is stored whole, and its checksum is verified before any byte is released. Only verified payloads are replayed on a valid/ready byte stream to the command layer; malformed, truncated or overrun frames are reported on an error pulse with a code.

## Interface
- MAX_LEN, 16: maximum payload bytes per packet (1..255); sets buffer depth.
- TIMEOUT_CYCLES, 208320: inter-byte timeout in clk cycles, equal to 2 byte times at 9600 baud on 100 MHz.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low; the only reset.
- in_data  in  8  received byte; valid only while in_valid=1.
- in_valid  in  1  one-cycle pulse per received byte; no backpressure possible.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts; a handshake occurs when out_valid and out_ready are both 1.
- out_last  out  1  marks the final payload byte; qualified by out_valid.
- pkt_ok  out  1  one-cycle pulse after the last payload byte is handshaken.
- pkt_err  out  1  one-cycle pulse on any error.
- err_code  out  2  code of the most recent error: 0 BAD_LEN, 1 BAD_CHK, 2 TIMEOUT, 3 OVERRUN. Holds until the next error.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States and transitions:
  - IDLE: waits for a byte equal to SOF (8'hA5), then goes to LEN. Any other byte is discarded silently with no error.
  - LEN: the LEN byte is accepted. If it is 0 or greater than MAX_LEN: pkt_err with BAD_LEN, go to IDLE. Otherwise latch len, clear the write index, set sum to LEN, go to PAYLOAD.
  - PAYLOAD: each byte is written to buf[idx], and sum is updated as sum + byte mod 256. After byte number len, go to CHK.
  - CHK: if the byte equals sum, go to EMIT with read index 0. Otherwise pkt_err with BAD_CHK, go to IDLE.
  - EMIT: out_valid=1 and out_data=buf[rd_idx]. out_last=1 when rd_idx equals len-1. Each handshake advances rd_idx. On the last handshake: go to IDLE and pulse pkt_ok.
- Checksum is the 8-bit wrapping sum of LEN and all payload bytes. SOF is excluded.
- Timeout applies in LEN, PAYLOAD and CHK only:
  - A counter clears on entry to these states and on every accepted byte, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: pkt_err with TIMEOUT, go to IDLE.
  - If in_valid arrives in the same cycle as the timeout, the byte wins: it is processed and the counter clears.
- In EMIT, every in_valid byte is dropped and pulses pkt_err with OVERRUN. Emission continues unaffected. A dropped byte is never taken as SOF.
- A byte equal to 8'hA5 in LEN, PAYLOAD or CHK is treated as data. There is no resynchronisation mid-frame.
- out_valid, once asserted, stays high with out_data stable until the handshake (no withdrawal).
- Reset values:
  - Outputs: out_valid=0, out_last=0, out_data=0, pkt_ok=0, pkt_err=0, err_code=0, busy=0.
  - Internal: state IDLE, all counters 0. Buffer contents need not be reset.
- Reset mid-packet or mid-EMIT abandons the packet, with no pkt_err and no pkt_ok.

## Timing
- All outputs are registered except out_data and out_last, which are decoded from the registered rd_idx and buffer.
- CHK byte on in_valid at cycle N: state is EMIT and out_valid=1 at cycle N+1.
- With out_ready held high, one byte is transferred per cycle, so a len-byte payload finishes on cycle N+len.
- pkt_ok and pkt_err pulse in the cycle after the causing event. err_code updates in that same cycle.
- A byte arriving in the cycle after the final handshake sees IDLE and may be SOF.
- The minimum input spacing (one byte time, about 104k cycles) exceeds worst-case EMIT under continuous ready. OVERRUN is therefore only reachable with consumer stalls.

## Structure
- The shared package uart_pkg holds:
  - SOF_BYTE = 8'hA5;
  - the err_code localparams ERR_BAD_LEN, ERR_BAD_CHK, ERR_TIMEOUT, ERR_OVERRUN;
  - the parser state encoding (3-bit: IDLE, LEN, PAYLOAD, CHK, EMIT).
- One sub-module, uart_pkt_buf: a MAX_LEN x 8 register array with one synchronous write port and one combinational read port, indexed by clog2(MAX_LEN) bits.
- Timeout counter width is clog2(TIMEOUT_CYCLES), 18 bits at the default.

## Test plan
- Good packet: bytes A5 03 11 22 33 69 with out_ready=1 → out_data 11, 22, 33 on 3 consecutive cycles; out_last only on 33; pkt_ok once; pkt_err never.
- Bad checksum: bytes A5 02 10 20 31 → no out_valid; pkt_err with err_code=1; busy drops. The following frame A5 01 7F 80 is emitted normally.
- Length errors:
  - A5 00 → BAD_LEN (0).
  - A5 11 with MAX_LEN=16 → BAD_LEN (0).
  - Leading noise 00 FF 5A before a good frame → silently discarded, and the frame is still parsed.
- Timeout: A5 02 AA, then silence for TIMEOUT_CYCLES → pkt_err with code 2 exactly TIMEOUT_CYCLES cycles after the AA byte's in_valid. A byte injected on the expiry cycle instead is accepted, with no error.
- Overrun and backpressure:
  - Setup: hold out_ready=0 after a good 2-byte frame, and inject byte A5.
  - Expected: pkt_err with code 3; out_data holds the first byte stably; release of out_ready completes the emission with pkt_ok; A5 is not taken as a start.
- Reset: assert rst_n low mid-PAYLOAD and mid-EMIT → all outputs return to their reset values asynchronously; no pulse occurs; the next good frame parses correctly.
